mem_lsu: RTL and testbench
==========================

# mem_lsu

Load/store unit between the pipeline's memory stage and the word-addressed data memory. Accepts one byte-addressed load or store per request over a valid/ready handshake and converts it into word accesses. The data memory has an asynchronous read port and a synchronous write port. Sub-word stores use a two-cycle read-modify-write; loads are lane-extracted and sign- or zero-extended.

## Interface
Parameters:
- `WIDTH`, 32, data word width; only 32 is supported.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset; synchronous, active-low (0 = reset).
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_signed`  in  1  sign-extend a sub-word load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer takes the response.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `resp_err`  out  1  request rejected; no memory write occurred.
- `mem_addr`  out  32  word address, equal to the latched byte address with bits [31:2] shifted into [29:0] and bits [31:30] = 0.
- `mem_in`  out  32  write data to memory.
- `mem_we`  out  1  memory write enable.
- `mem_out`  in  32  asynchronous read data for `mem_addr`.

## Operation
State machine: IDLE, ACCESS, WRITE, RESP.
- **IDLE**
  - `req_ready` = 1.
  - On `req_valid`, latch `req_we`, `req_size`, `req_signed`, `req_addr` and `req_wdata`, then go to ACCESS.
- **ACCESS**
  - `mem_addr` is driven from the latched address.
  - Error request: size 3, or (with the macro enabled) a misaligned address. Go to RESP with `resp_err` = 1. `mem_we` stays 0.
  - Load:
    - Select byte lane `addr[1:0]` (size 0) or half lane `addr[1]` (size 1). Byte k occupies bits [8k+7:8k] (little-endian lanes).
    - Extend the selected lane to 32 bits: sign-extend if `req_signed`, else zero-extend.
    - Register the result into `resp_rdata` and go to RESP.
  - Word store: `mem_we` = 1, `mem_in` = wdata, go to RESP.
  - Sub-word store:
    - Register `mem_out` with the target lane replaced by wdata[7:0] or wdata[15:0].
    - Go to WRITE.
- **WRITE**
  - `mem_we` = 1, `mem_in` = merged word.
  - Go to RESP.
- **RESP**
  - `resp_valid` = 1.
  - Hold `resp_rdata` and `resp_err` stable until `resp_ready`.
  - On `resp_ready`, go to IDLE.
- `req_ready` = 0 in every state except IDLE. No request is accepted in the cycle a response is consumed.
- `mem_we` is asserted only in ACCESS (word store) or WRITE. It is never asserted for errors or loads.
- Reset:
  - State IDLE.
  - `resp_valid` = 0, `resp_rdata` = 0, `resp_err` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_in` = 0.
  - Reset in ACCESS or WRITE aborts the operation. If `rst` is low during the WRITE cycle, no memory write occurs.

## Timing
- Request accepted at edge T (state IDLE → ACCESS).
- Load, word store, or error: `resp_valid` is high in the cycle after edge T+1.
- Sub-word store: memory is written at edge T+2; `resp_valid` is high after edge T+2.
- A response consumed at edge R makes `req_ready` = 1 after R; the next request is accepted at R+1 at the earliest.
- Throughput is one request per 3 cycles (4 for sub-word stores) with `resp_ready` tied high.
- All outputs are registered or decoded from the state register only. There is no combinational path from `req_*` or `resp_ready` to outputs.

## Configuration
- `LSU_MISALIGN_EXC_EN` defined:
  - A half access with `addr[0]` = 1, or a word access with `addr[1:0]` ≠ 0, produces `resp_err` = 1.
  - No memory write occurs for such an access.
- `LSU_MISALIGN_EXC_EN` not defined:
  - The low address bits below the access size are ignored: a half access uses `addr[1]` only, and a word access ignores `addr[1:0]`.
  - `resp_err` is raised only for size 3.

## Structure
- Shared header `LSU_DEFS.v` holds:
  - size encodings `LSU_SZ_B`, `LSU_SZ_H`, `LSU_SZ_W`;
  - state encodings;
  - the word width constant.
- One combinational sub-module `lsu_lane` contains lane extraction with extension and lane merge for stores. Both operations are driven by `addr[1:0]`, size and signed. The FSM and handshake stay in `mem_lsu`.

## Test plan
- Preload word 0 = 0x8070_60F0. Issue load byte signed at addr 0 → `resp_rdata` 0xFFFF_FFF0. Load byte unsigned at addr 3 → 0x0000_0080. Each response arrives 2 cycles after acceptance.
- Word 1 = 0x1122_3344. Store byte 0xAB at addr 6 → `mem_we` pulses once, 2 cycles after acceptance. A subsequent word load at 4 returns 0x11AB_3344.
- Store half 0xBEEF at addr 8 over 0xFFFF_FFFF → memory 0xFFFF_BEEF. Load half signed at addr 8 → 0xFFFF_BEEF.
- `req_size` = 3 → `resp_err` = 1, `resp_rdata` = 0, `mem_we` never asserted. With the macro enabled, a word load at addr 2 → `resp_err` = 1. With the macro disabled, the same load returns the word at addr 0.
- Hold `resp_ready` low for 5 cycles after a load → `resp_valid`, `resp_rdata` and `resp_err` stay stable and `req_ready` stays 0 throughout.
- Assert `rst` = 0 during WRITE of a sub-word store → no write; memory is unchanged. All outputs take their reset values and `req_ready` = 1 after reset release.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM states, word width
// and the alignment helper.
package mem_lsu_pkg;

  localparam int unsigned LsuWidth = 32;

  localparam logic [1:0] LsuSzB = 2'd0;
  localparam logic [1:0] LsuSzH = 2'd1;
  localparam logic [1:0] LsuSzW = 2'd2;
  localparam logic [1:0] LsuSzX = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StWrite  = 2'd2,
    StResp   = 2'd3
  } lsu_state_e;

  // True when the low address bits are not a multiple of the access size.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      LsuSzH:  return addr[0];
      LsuSzW:  return addr != 2'd0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_lane.sv
// Byte/half lane handling: extracts and extends a load lane, and merges store data into
// a read word. Purely combinational.
module mem_lsu_lane
  import mem_lsu_pkg::*;
(
  input  logic [1:0]          addr_i,
  input  logic [1:0]          size_i,
  input  logic                signed_i,
  input  logic [LsuWidth-1:0] rdata_i,
  input  logic [LsuWidth-1:0] wdata_i,
  output logic [LsuWidth-1:0] load_o,
  output logic [LsuWidth-1:0] merged_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata_i[7:0];
    unique case (addr_i)
      2'd0: byte_lane = rdata_i[7:0];
      2'd1: byte_lane = rdata_i[15:8];
      2'd2: byte_lane = rdata_i[23:16];
      2'd3: byte_lane = rdata_i[31:24];
    endcase
    half_lane = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    load_o = rdata_i;
    case (size_i)
      LsuSzB:  load_o = {{24{signed_i & byte_lane[7]}}, byte_lane};
      LsuSzH:  load_o = {{16{signed_i & half_lane[15]}}, half_lane};
      default: load_o = rdata_i;
    endcase
  end

  always_comb begin
    merged_o = rdata_i;
    case (size_i)
      LsuSzB: begin
        unique case (addr_i)
          2'd0: merged_o[7:0]   = wdata_i[7:0];
          2'd1: merged_o[15:8]  = wdata_i[7:0];
          2'd2: merged_o[23:16] = wdata_i[7:0];
          2'd3: merged_o[31:24] = wdata_i[7:0];
        endcase
      end
      LsuSzH: begin
        if (addr_i[1]) merged_o[31:16] = wdata_i[15:0];
        else           merged_o[15:0]  = wdata_i[15:0];
      end
      LsuSzW:  merged_o = wdata_i;
      default: merged_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: byte-addressed requests to a word memory, read-modify-write for sub-word
// stores. Define LSU_MISALIGN_EXC_EN to reject misaligned half/word accesses.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned WIDTH = LsuWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_signed,
  input  logic [31:0]      req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic [31:0]      mem_addr,
  output logic [WIDTH-1:0] mem_in,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_out
);

  lsu_state_e state_q, state_d;

  logic             we_q, we_d;
  logic [1:0]       size_q, size_d;
  logic             signed_q, signed_d;
  logic [31:0]      addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] merged_q, merged_d;

  logic             req_err;
  logic [WIDTH-1:0] load_word;
  logic [WIDTH-1:0] merged_word;

`ifdef LSU_MISALIGN_EXC_EN
  assign req_err = (size_q == LsuSzX) || lsu_misaligned(size_q, addr_q[1:0]);
`else
  assign req_err = (size_q == LsuSzX);
`endif

  mem_lsu_lane u_lane (
    .addr_i   (addr_q[1:0]),
    .size_i   (size_q),
    .signed_i (signed_q),
    .rdata_i  (mem_out),
    .wdata_i  (wdata_q),
    .load_o   (load_word),
    .merged_o (merged_word)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req_valid) state_d = StAccess;
      StAccess: state_d = (we_q && !req_err && size_q != LsuSzW) ? StWrite : StResp;
      StWrite:  state_d = StResp;
      StResp:   if (resp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    merged_d = merged_q;
    if (state_q == StIdle && req_valid) begin
      we_d     = req_we;
      size_d   = req_size;
      signed_d = req_signed;
      addr_d   = req_addr;
      wdata_d  = req_wdata;
    end
    if (state_q == StAccess) begin
      rdata_d  = (!we_q && !req_err) ? load_word : '0;
      err_d    = req_err;
      merged_d = merged_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q     <= 1'b0;
      size_q   <= LsuSzB;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      merged_q <= '0;
    end else begin
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      merged_q <= merged_d;
    end
  end

  // Write enable is gated by reset so an abort in the WRITE cycle never reaches memory.
  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = (state_q == StResp);
    resp_rdata = rdata_q;
    resp_err   = err_q;
    mem_addr   = {2'b00, addr_q[31:2]};
    mem_in     = (state_q == StWrite) ? merged_q : wdata_q;
    mem_we     = rst && ((state_q == StWrite) ||
                         (state_q == StAccess && we_q && !req_err && size_q == LsuSzW));
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: vector table driven through a response scoreboard,
// plus backpressure and reset-during-write sequences.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_in;
  logic        mem_we;
  logic [31:0] mem_out;

  always #5 clk = ~clk;

  mem_lsu #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_in     (mem_in),
    .mem_we     (mem_we),
    .mem_out    (mem_out)
  );

  // Word memory: asynchronous read, synchronous write, preloaded before the first request.
  logic [31:0] mem [16];
  logic        init_done;

  assign mem_out = mem[mem_addr[3:0]];

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h8070_60F0;
      mem[1] <= 32'h1122_3344;
      mem[2] <= 32'hFFFF_FFFF;
    end else if (mem_we) begin
      mem[mem_addr[3:0]] <= mem_in;
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  vec_t  vecs[$];
  resp_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;

`ifdef LSU_MISALIGN_EXC_EN
  localparam logic        MisErr = 1'b1;
  localparam logic [31:0] W1Final = 32'h11AB_3344;
  localparam logic [31:0] MisWordLoad = 32'h0;
`else
  localparam logic        MisErr = 1'b0;
  localparam logic [31:0] W1Final = 32'h11AB_5566;
  localparam logic [31:0] MisWordLoad = 32'h8070_60F0;
`endif

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, wanted %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_valid  = 1'b1;
    req_we     = v.we;
    req_size   = v.size;
    req_signed = v.sgn;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
  endtask

  // Called just after the accepting edge; returns after the response is consumed.
  task automatic wait_resp(input int exp_lat, input int exp_we);
    int    lat;
    int    wes;
    resp_t r;
    lat = 0;
    wes = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
      if (mem_we) wes++;
    end while (!resp_valid && lat < 8);
    check("latency", 32'(lat), 32'(exp_lat));
    check("mem_we_pulses", 32'(wes), 32'(exp_we));
    check("req_ready_in_resp", 32'(req_ready), 32'd0);
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_empty: got response, wanted none");
    end else begin
      r = sb.pop_front();
      check("resp_rdata", resp_rdata, r.rdata);
      check("resp_err", 32'(resp_err), 32'(r.err));
    end
    @(posedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    logic sub_store;
    logic good_store;
    good_store = v.we && !v.exp_err;
    sub_store  = good_store && v.size != 2'd2;
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    drive(v);
    @(posedge clk);
    wait_resp(sub_store ? 3 : 2, good_store ? 1 : 0);
  endtask

  initial begin
    vec_t v;
    rst        = 1'b0;
    init_done  = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b1;

    //            we    sz    sgn   addr   wdata          rdata          err
    vecs.push_back(mk(1'b0, 2'd0, 1'b1, 32'd0, 32'h0, 32'hFFFF_FFF0, 1'b0));
    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 32'd3, 32'h0, 32'h0000_0080, 1'b0));
    vecs.push_back(mk(1'b1, 2'd0, 1'b0, 32'd6, 32'hFFFF_FFAB, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 2'd2, 1'b0, 32'd4, 32'h0, 32'h11AB_3344, 1'b0));
    vecs.push_back(mk(1'b1, 2'd1, 1'b0, 32'd5, 32'h7777_5566, 32'h0, MisErr));
    vecs.push_back(mk(1'b0, 2'd2, 1'b0, 32'd4, 32'h0, W1Final, 1'b0));
    vecs.push_back(mk(1'b1, 2'd1, 1'b0, 32'd8, 32'h0000_BEEF, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 2'd1, 1'b1, 32'd8, 32'h0, 32'hFFFF_BEEF, 1'b0));
    vecs.push_back(mk(1'b0, 2'd1, 1'b0, 32'd2, 32'h0, 32'h0000_8070, 1'b0));
    vecs.push_back(mk(1'b0, 2'd1, 1'b1, 32'd2, 32'h0, 32'hFFFF_8070, 1'b0));
    vecs.push_back(mk(1'b0, 2'd3, 1'b0, 32'd0, 32'h0, 32'h0, 1'b1));
    vecs.push_back(mk(1'b1, 2'd3, 1'b0, 32'd4, 32'hFFFF_FFFF, 32'h0, 1'b1));
    vecs.push_back(mk(1'b0, 2'd2, 1'b0, 32'd4, 32'h0, W1Final, 1'b0));
    vecs.push_back(mk(1'b0, 2'd2, 1'b0, 32'd2, 32'h0, MisWordLoad, MisErr));
    vecs.push_back(mk(1'b1, 2'd2, 1'b0, 32'd12, 32'hDEAD_BEEF, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 2'd2, 1'b0, 32'd12, 32'h0, 32'hDEAD_BEEF, 1'b0));
    vecs.push_back(mk(1'b0, 2'd0, 1'b1, 32'd1, 32'h0, 32'h0000_0060, 1'b0));
    vecs.push_back(mk(1'b1, 2'd1, 1'b0, 32'd14, 32'hAAAA_1234, 32'h0, 1'b0));
    vecs.push_back(mk(1'b0, 2'd2, 1'b0, 32'd12, 32'h0, 32'h1234_BEEF, 1'b0));
    vecs.push_back(mk(1'b0, 2'd0, 1'b0, 32'd13, 32'h0, 32'h0000_00BE, 1'b0));
    vecs.push_back(mk(1'b0, 2'd0, 1'b1, 32'd13, 32'h0, 32'hFFFF_FFBE, 1'b0));

    repeat (2) @(posedge clk);
    init_done = 1'b1;
    @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_in", mem_in, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    rst = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: response held for 5 cycles while another request waits.
    @(negedge clk);
    resp_ready = 1'b0;
    drive(mk(1'b0, 2'd0, 1'b1, 32'd0, 32'h0, 32'hFFFF_FFF0, 1'b0));
    @(posedge clk);
    begin
      int lat;
      lat = 0;
      do begin
        @(negedge clk);
        req_valid = 1'b0;
        lat++;
      end while (!resp_valid && lat < 8);
      check("bp_latency", 32'(lat), 32'd2);
    end
    v = mk(1'b0, 2'd2, 1'b0, 32'd8, 32'h0, 32'hFFFF_BEEF, 1'b0);
    req_valid = 1'b1;
    req_we    = v.we;
    req_size  = v.size;
    req_addr  = v.addr;
    for (int i = 0; i < 5; i++) begin
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_resp_rdata", resp_rdata, 32'hFFFF_FFF0);
      check("bp_resp_err", 32'(resp_err), 32'd0);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    begin
      resp_t r;
      r = sb.pop_front();
      check("bp_sb_rdata", resp_rdata, r.rdata);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_ready_after_consume", 32'(req_ready), 32'd1);
    check("bp_valid_after_consume", 32'(resp_valid), 32'd0);
    drive(v);
    @(posedge clk);
    wait_resp(2, 0);

    // Reset during the WRITE cycle of a sub-word store must suppress the write.
    @(negedge clk);
    drive(mk(1'b1, 2'd0, 1'b0, 32'd8, 32'h0000_0000, 32'h0, 1'b0));
    void'(sb.pop_back());
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort_access_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    check("abort_write_we_before", 32'(mem_we), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_write_we_gated", 32'(mem_we), 32'd0);
    @(negedge clk);
    check("abort_mem_unchanged", mem[2], 32'hFFFF_BEEF);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_resp_rdata", resp_rdata, 32'd0);
    check("abort_mem_addr", mem_addr, 32'd0);
    check("abort_mem_in", mem_in, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    run_vec(mk(1'b0, 2'd2, 1'b0, 32'd8, 32'h0, 32'hFFFF_BEEF, 1'b0));

    check("final_word1", mem[1], W1Final);
    check("final_word3", mem[3], 32'h1234_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, wanted completion");
    $fatal(1, "watchdog expired");
  end

endmodule
